// File: rtl/shreg_pkg.sv
// Shared op-codes, FSM state encoding and op classification for the shift register engine.
package shreg_pkg;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_SHL  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  function automatic logic is_shift_op(input logic [2:0] op);
    case (op)
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shreg_step.sv
// Combinational single-step next-value logic; non-shift ops pass q through unchanged.
module shreg_step
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] q,
  input  logic             sin,
  output logic [WIDTH-1:0] q_step
);

  always_comb begin
    q_step = q;
    case (op)
      OP_SHL:  q_step = {q[WIDTH-2:0], sin};
      OP_SHR:  q_step = {sin, q[WIDTH-1:1]};
      OP_ROL:  q_step = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROR:  q_step = {q[0], q[WIDTH-1:1]};
      default: q_step = q;
    endcase
  end

endmodule

// File: rtl/shift_reg_engine.sv
// Universal shift register with command handshake: load, and burst shift/rotate by a count.
// Optional registered parity output enabled by defining SHREG_PARITY_EN.
module shift_reg_engine
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  input  logic             stall,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
`ifdef SHREG_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [0:0]       state, state_next;
  logic [2:0]       op_r, op_next;
  logic [CNT_W-1:0] remaining, rem_next;
  logic [WIDTH-1:0] q_next, q_step;
  logic             done_next;
  logic             accept;

  shreg_step #(.WIDTH(WIDTH)) u_step (
    .op     (op_r),
    .q      (q),
    .sin    (sin),
    .q_step (q_step)
  );

  assign busy      = (state == ST_SHIFT);
  assign cmd_ready = ~busy;
  assign accept    = cmd_valid & cmd_ready;
  assign sout_l    = q[WIDTH-1];
  assign sout_r    = q[0];

  // Next-state is computed in one place so parity can be registered from q_next on the same edge as q.
  always_comb begin
    state_next = state;
    op_next    = op_r;
    rem_next   = remaining;
    q_next     = q;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_LOAD) begin
            q_next    = din;
            done_next = 1'b1;
          end else if (is_shift_op(cmd_op) && (cmd_count != '0)) begin
            state_next = ST_SHIFT;
            op_next    = cmd_op;
            rem_next   = cmd_count;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (!stall) begin
          q_next   = q_step;
          rem_next = remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_r      <= OP_LOAD;
      remaining <= '0;
      q         <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      op_r      <= op_next;
      remaining <= rem_next;
      q         <= q_next;
      done      <= done_next;
    end
  end

`ifdef SHREG_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity <= 1'b0;
    else     parity <= ^q_next;
  end
`endif

endmodule

// File: tb/tb_shift_reg_engine.sv
// Directed self-checking bench for shift_reg_engine (WIDTH=8, CNT_W=4).
module tb_shift_reg_engine;
  import shreg_pkg::*;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_count;
  logic [7:0] din;
  logic       sin;
  logic       stall;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;
`ifdef SHREG_PARITY_EN
  logic       parity;
`endif

  int tests;
  int fails;

  shift_reg_engine #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .din       (din),
    .sin       (sin),
    .stall     (stall),
    .q         (q),
    .sout_l    (sout_l),
    .sout_r    (sout_r),
    .busy      (busy),
    .done      (done)
`ifdef SHREG_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a command for one edge (caller ensures cmd_ready); returns 1 time unit after the edge.
  task automatic issue(input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    din       = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (q !== 8'h00) begin fails++; $display("FAIL reset_q: got %h want 00", q); end
    tests++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_flags: busy=%b done=%b ready=%b want 0 0 1", busy, done, cmd_ready);
    end
    issue(OP_LOAD, 4'd0, 8'h3C);
    sin = 1'b1;
    issue(OP_SHL, 4'd5, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (q !== 8'hF3 || busy !== 1'b1) begin
      fails++; $display("FAIL midburst_q: q=%h busy=%b want F3 1", q, busy);
    end
    #2 rst = 1'b1;
    #1;
    tests++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL async_reset: q=%h busy=%b done=%b ready=%b want 00 0 0 1", q, busy, done, cmd_ready);
    end
    #1 rst = 1'b0;
    sin = 1'b0;
    issue(OP_LOAD, 4'd0, 8'h5A);
    tests++; if (q !== 8'h5A || done !== 1'b1) begin
      fails++; $display("FAIL post_reset_cmd: q=%h done=%b want 5A 1", q, done);
    end
  endtask

  task automatic test_load;
    @(posedge clk); #1;
    issue(OP_LOAD, 4'd7, 8'hA5);
    tests++; if (q !== 8'hA5 || done !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL load: q=%h done=%b busy=%b want A5 1 0", q, done, busy);
    end
    tests++; if (sout_l !== 1'b1 || sout_r !== 1'b1) begin
      fails++; $display("FAIL load_sout: l=%b r=%b want 1 1", sout_l, sout_r);
    end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0 || q !== 8'hA5) begin
      fails++; $display("FAIL load_pulse: done=%b q=%h want 0 A5", done, q);
    end
  endtask

  task automatic test_rol_wrap;
    int busy_bad;
    busy_bad = 0;
    issue(OP_LOAD, 4'd0, 8'h81);
    issue(OP_ROL, 4'd9, 8'h00);
    if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
    for (int i = 1; i < 9; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
    end
    tests++; if (busy_bad != 0) begin
      fails++; $display("FAIL rol_busy: %0d bad cycles want 0", busy_bad);
    end
    @(posedge clk); #1;
    tests++; if (q !== 8'h03 || done !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL rol9: q=%h done=%b busy=%b want 03 1 0", q, done, busy);
    end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0) begin
      fails++; $display("FAIL rol_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_shl_stall;
    logic [7:0] pat;
    int idx;
    int edges;
    logic got;
    pat = 8'hB2;
    idx = 0;
    edges = 0;
    got = 1'b0;
    issue(OP_LOAD, 4'd0, 8'h00);
    issue(OP_SHL, 4'd8, 8'h00);
    while (edges < 40 && !got) begin
      stall = (edges + 1 >= 5) && (edges + 1 <= 7);
      sin   = (idx < 8) ? pat[7-idx] : 1'b0;
      @(posedge clk); #1;
      edges++;
      if (!stall) idx++;
      if (edges == 7) begin
        tests++; if (q !== 8'h0B || busy !== 1'b1) begin
          fails++; $display("FAIL stall_hold: q=%h busy=%b want 0B 1", q, busy);
        end
      end
      if (done) got = 1'b1;
    end
    stall = 1'b0;
    sin   = 1'b0;
    tests++; if (!got || edges != 11) begin
      fails++; $display("FAIL stall_latency: done_seen=%b edges=%0d want 1 11", got, edges);
    end
    tests++; if (q !== 8'hB2) begin
      fails++; $display("FAIL shl8: q=%h want B2", q);
    end
  endtask

  task automatic test_zero_count;
    issue(OP_LOAD, 4'd0, 8'h6C);
    issue(OP_SHR, 4'd0, 8'hFF);
    tests++; if (q !== 8'h6C || done !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL shr0: q=%h done=%b busy=%b want 6C 1 0", q, done, busy);
    end
    issue(OP_ROL, 4'd3, 8'h00);
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    din       = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    tests++; if (q !== 8'h63 || done !== 1'b1) begin
      fails++; $display("FAIL busy_ignore: q=%h done=%b want 63 1", q, done);
    end
    issue(OP_ROR + 3'd1, 4'd4, 8'h00);
    tests++; if (q !== 8'h63 || done !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reserved_nop: q=%h done=%b busy=%b want 63 1 0", q, done, busy);
    end
  endtask

  task automatic test_back_to_back;
    issue(OP_LOAD, 4'd0, 8'h96);
    issue(OP_ROR, 4'd1, 8'h00);
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_count = 4'd0;
    din       = 8'h3C;
    @(posedge clk); #1;
    tests++; if (q !== 8'h4B || done !== 1'b1 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_first: q=%h done=%b ready=%b want 4B 1 1", q, done, cmd_ready);
    end
`ifdef SHREG_PARITY_EN
    tests++; if (parity !== 1'b0) begin
      fails++; $display("FAIL parity_4b: got %b want 0", parity);
    end
`endif
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    tests++; if (q !== 8'h3C || done !== 1'b1) begin
      fails++; $display("FAIL b2b_second: q=%h done=%b want 3C 1", q, done);
    end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL b2b_idle: done=%b busy=%b want 0 0", done, busy);
    end
`ifdef SHREG_PARITY_EN
    issue(OP_LOAD, 4'd0, 8'h07);
    tests++; if (parity !== 1'b1) begin
      fails++; $display("FAIL parity_07: got %b want 1", parity);
    end
`endif
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_LOAD;
    cmd_count = 4'd0;
    din       = 8'h00;
    sin       = 1'b0;
    stall     = 1'b0;
    test_reset;
    test_load;
    test_rol_wrap;
    test_shl_stall;
    test_zero_count;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
